// File: rtl/vx_ibuffer_multi.sv
// -----------------------------------------------------------------------------
// vx_ibuffer_multi
//
// Per-warp instruction buffer for the issue stage. Decoded instructions are
// held in one circular FIFO per warp and leave through a single round-robin
// arbitrated valid/ready port towards scoreboard/dispatch. A warp can be
// flushed (branch / warp kill) or held out of arbitration (scoreboard stall).
//
// Ports:
//   clk          clock
//   reset_n      synchronous active-low reset
//   enq_valid    decode offers an instruction
//   enq_wid      target warp of the enqueue
//   enq_data     instruction payload
//   enq_ready    target queue can accept (independent of deq_ready)
//   flush_valid  discard every entry of flush_wid at this edge
//   flush_wid    warp to flush
//   stall_mask   bit w=1 removes warp w from arbitration
//   deq_valid    an instruction is presented
//   deq_wid      warp of the presented instruction
//   deq_data     head entry of warp deq_wid (don't-care when deq_valid=0)
//   deq_ready    consumer accepts
//   empty_mask   bit w=1 when queue w holds no entries
//   full_mask    bit w=1 when queue w holds DEPTH entries
// -----------------------------------------------------------------------------
module vx_ibuffer_multi #(
    parameter int NUM_WARPS = 4,
    parameter int DEPTH     = 4,
    parameter int DATAW     = 128,
    parameter int WID_W     = $clog2(NUM_WARPS)
) (
    input  logic                 clk,
    input  logic                 reset_n,

    input  logic                 enq_valid,
    input  logic [WID_W-1:0]     enq_wid,
    input  logic [DATAW-1:0]     enq_data,
    output logic                 enq_ready,

    input  logic                 flush_valid,
    input  logic [WID_W-1:0]     flush_wid,
    input  logic [NUM_WARPS-1:0] stall_mask,

    output logic                 deq_valid,
    output logic [WID_W-1:0]     deq_wid,
    output logic [DATAW-1:0]     deq_data,
    input  logic                 deq_ready,

    output logic [NUM_WARPS-1:0] empty_mask,
    output logic [NUM_WARPS-1:0] full_mask
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Payload storage is never cleared; only pointers and counts are.
    logic [DATAW-1:0] mem_q [NUM_WARPS][DEPTH];

    logic [PTR_W-1:0] rd_ptr_q [NUM_WARPS];
    logic [PTR_W-1:0] rd_ptr_d [NUM_WARPS];
    logic [PTR_W-1:0] wr_ptr_q [NUM_WARPS];
    logic [PTR_W-1:0] wr_ptr_d [NUM_WARPS];
    logic [CNT_W-1:0] count_q  [NUM_WARPS];
    logic [CNT_W-1:0] count_d  [NUM_WARPS];
    logic [WID_W-1:0] last_grant_q;
    logic [WID_W-1:0] last_grant_d;

    logic [NUM_WARPS-1:0] q_empty;
    logic [NUM_WARPS-1:0] q_full;
    logic [NUM_WARPS-1:0] flush_hit;
    logic [NUM_WARPS-1:0] eligible;
    logic [NUM_WARPS-1:0] enq_hit;
    logic [NUM_WARPS-1:0] deq_hit;

    logic             enq_fire;
    logic             deq_fire;
    logic             sel_found;
    logic [WID_W-1:0] sel_wid;
    int               rr_idx;

    // Per-warp status, all derived from registered counts.
    always_comb begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            q_empty[w]   = (count_q[w] == '0);
            q_full[w]    = (count_q[w] == CNT_W'(DEPTH));
            flush_hit[w] = flush_valid && (flush_wid == WID_W'(w));
            eligible[w]  = !q_empty[w] && !stall_mask[w] && !flush_hit[w];
        end
    end

    // A warp being flushed refuses writes so its clear cannot race an enqueue.
    assign enq_ready = reset_n && !q_full[enq_wid] && !flush_hit[enq_wid];
    assign enq_fire  = enq_valid && enq_ready;

    // Round-robin search starting one past the last granted warp.
    always_comb begin
        sel_found = 1'b0;
        sel_wid   = '0;
        rr_idx    = 0;
        for (int i = 1; i <= NUM_WARPS; i++) begin
            rr_idx = int'(last_grant_q) + i;
            if (rr_idx >= NUM_WARPS) begin
                rr_idx = rr_idx - NUM_WARPS;
            end
            if (!sel_found && eligible[WID_W'(rr_idx)]) begin
                sel_found = 1'b1;
                sel_wid   = WID_W'(rr_idx);
            end
        end
    end

    assign deq_valid = reset_n && sel_found;
    assign deq_wid   = sel_wid;
    assign deq_data  = mem_q[sel_wid][rd_ptr_q[sel_wid]];
    assign deq_fire  = deq_valid && deq_ready;

    // Masks are forced to their reset appearance while reset_n is held low.
    assign empty_mask = reset_n ? q_empty : '1;
    assign full_mask  = reset_n ? q_full  : '0;

    always_comb begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            enq_hit[w] = enq_fire && (enq_wid == WID_W'(w));
            deq_hit[w] = deq_fire && (sel_wid == WID_W'(w));
        end
    end

    // Next-state for pointers, counts and the arbitration pointer.
    always_comb begin
        last_grant_d = last_grant_q;
        if (deq_fire) begin
            last_grant_d = sel_wid;
        end
        for (int w = 0; w < NUM_WARPS; w++) begin
            rd_ptr_d[w] = rd_ptr_q[w];
            wr_ptr_d[w] = wr_ptr_q[w];
            count_d[w]  = count_q[w];
            if (flush_hit[w]) begin
                rd_ptr_d[w] = '0;
                wr_ptr_d[w] = '0;
                count_d[w]  = '0;
            end else begin
                if (enq_hit[w]) begin
                    wr_ptr_d[w] = wr_ptr_q[w] + PTR_W'(1);
                end
                if (deq_hit[w]) begin
                    rd_ptr_d[w] = rd_ptr_q[w] + PTR_W'(1);
                end
                // Simultaneous enqueue and dequeue leave the count unchanged.
                if (enq_hit[w] && !deq_hit[w]) begin
                    count_d[w] = count_q[w] + CNT_W'(1);
                end else if (!enq_hit[w] && deq_hit[w]) begin
                    count_d[w] = count_q[w] - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                rd_ptr_q[w] <= '0;
                wr_ptr_q[w] <= '0;
                count_q[w]  <= '0;
            end
            // Warp 0 gets first priority after reset.
            last_grant_q <= WID_W'(NUM_WARPS - 1);
        end else begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                rd_ptr_q[w] <= rd_ptr_d[w];
                wr_ptr_q[w] <= wr_ptr_d[w];
                count_q[w]  <= count_d[w];
            end
            last_grant_q <= last_grant_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq_fire) begin
            mem_q[enq_wid][wr_ptr_q[enq_wid]] <= enq_data;
        end
    end

endmodule
